// File: rtl/inst_cycle_ctrl.sv
// Multi-cycle instruction sequencer: IF -> ID -> EX -> [MEM] -> WB -> COMMIT.
// Inserts MEM only for loads/stores, with a bounded wait on mem_rdy_i. Halts on trap.
module inst_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_ren_i,
  input  logic             mem_wen_i,
  input  logic             mem_rdy_i,
  input  logic             trap_i,
  output logic             if_en_o,
  output logic             id_en_o,
  output logic             ex_en_o,
  output logic             mem_req_o,
  output logic             wb_en_o,
  output logic             commit_o,
  output logic [3:0]       state_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_IF     = 4'd1,
    S_ID     = 4'd2,
    S_EX     = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_COMMIT = 4'd6,
    S_HALT   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic [WAIT_W-1:0] wait_inc;
  logic              halted_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  cycle_reg;
  logic [CNT_W-1:0]  instr_reg;

  assign wait_inc = wait_reg + WAIT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      wait_reg   <= '0;
      halted_reg <= 1'b0;
      err_reg    <= 1'b0;
      cycle_reg  <= '0;
      instr_reg  <= '0;
    end else begin
      // Cycle counter freezes once the core has stopped for good.
      if (state_reg != S_HALT && state_reg != S_ERR)
        cycle_reg <= cycle_reg + CNT_W'(1);

      case (state_reg)
        S_IDLE: state_reg <= S_IF;
        S_IF:   state_reg <= S_ID;
        S_ID:   state_reg <= S_EX;
        S_EX: begin
          if (mem_ren_i && mem_wen_i) begin
            state_reg <= S_ERR;
            err_reg   <= 1'b1;
          end else if (mem_ren_i || mem_wen_i) begin
            state_reg <= S_MEM;
            wait_reg  <= '0;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          // Ready takes priority over a timeout firing in the same cycle.
          if (mem_rdy_i) begin
            state_reg <= S_WB;
          end else if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            state_reg <= S_ERR;
            err_reg   <= 1'b1;
          end else begin
            wait_reg <= wait_inc;
          end
        end
        S_WB: state_reg <= S_COMMIT;
        S_COMMIT: begin
          instr_reg <= instr_reg + CNT_W'(1);
          if (trap_i) begin
            state_reg  <= S_HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg <= S_IF;
          end
        end
        S_HALT: state_reg <= S_HALT;
        S_ERR:  state_reg <= S_ERR;
        default: begin
          state_reg <= S_ERR;
          err_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign if_en_o     = (state_reg == S_IF);
  assign id_en_o     = (state_reg == S_ID);
  assign ex_en_o     = (state_reg == S_EX);
  assign mem_req_o   = (state_reg == S_MEM);
  assign wb_en_o     = (state_reg == S_WB);
  assign commit_o    = (state_reg == S_COMMIT);
  assign state_o     = state_reg;
  assign halted_o    = halted_reg;
  assign err_o       = err_reg;
  assign cycle_cnt_o = cycle_reg;
  assign instr_cnt_o = instr_reg;

endmodule

// File: tb/tb_inst_cycle_ctrl.sv
// Directed bench for inst_cycle_ctrl: per-cycle expectations go through a scoreboard
// queue and are compared against every output after each clock edge.
module tb_inst_cycle_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0, S_IF = 4'd1, S_ID = 4'd2, S_EX = 4'd3, S_MEM = 4'd4,
                         S_WB = 4'd5, S_COMMIT = 4'd6, S_HALT = 4'd7, S_ERR = 4'd8;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_ren_i, mem_wen_i, mem_rdy_i, trap_i;
  logic        if_en_o, id_en_o, ex_en_o, mem_req_o, wb_en_o, commit_o;
  logic [3:0]  state_o;
  logic        halted_o, err_o;
  logic [63:0] cycle_cnt_o, instr_cnt_o;

  inst_cycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(64)) dut (
    .clock(clock), .reset(reset),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .mem_rdy_i(mem_rdy_i), .trap_i(trap_i),
    .if_en_o(if_en_o), .id_en_o(id_en_o), .ex_en_o(ex_en_o), .mem_req_o(mem_req_o),
    .wb_en_o(wb_en_o), .commit_o(commit_o), .state_o(state_o),
    .halted_o(halted_o), .err_o(err_o),
    .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [5:0]  en;
    logic [1:0]  flags;
    logic [63:0] cyc;
    logic [63:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          req_cycles = 0;
  logic [3:0]  cur_st = S_IDLE;
  logic [63:0] m_cyc = '0;
  logic [63:0] m_ins = '0;
  logic        m_halt = 1'b0;
  logic        m_err = 1'b0;

  // {if, id, ex, mem, wb, commit}
  function automatic logic [5:0] dec(input logic [3:0] s);
    case (s)
      S_IF:     return 6'b100000;
      S_ID:     return 6'b010000;
      S_EX:     return 6'b001000;
      S_MEM:    return 6'b000100;
      S_WB:     return 6'b000010;
      S_COMMIT: return 6'b000001;
      default:  return 6'b000000;
    endcase
  endfunction

  task automatic check_out();
    exp_t e;
    logic [5:0] en_obs;
    e = sb.pop_front();
    en_obs = {if_en_o, id_en_o, ex_en_o, mem_req_o, wb_en_o, commit_o};
    vectors++;
    assert (state_o === e.st) else begin
      miscompares++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, state_o, e.st);
    end
    vectors++;
    assert (en_obs === e.en) else begin
      miscompares++;
      $error("FAIL %s enables: got %b expected %b", e.tag, en_obs, e.en);
    end
    vectors++;
    assert ({halted_o, err_o} === e.flags) else begin
      miscompares++;
      $error("FAIL %s halt/err: got %b expected %b", e.tag, {halted_o, err_o}, e.flags);
    end
    vectors++;
    assert (cycle_cnt_o === e.cyc) else begin
      miscompares++;
      $error("FAIL %s cycle_cnt: got %0d expected %0d", e.tag, cycle_cnt_o, e.cyc);
    end
    vectors++;
    assert (instr_cnt_o === e.ins) else begin
      miscompares++;
      $error("FAIL %s instr_cnt: got %0d expected %0d", e.tag, instr_cnt_o, e.ins);
    end
  endtask

  // Advance one clock expecting state nxt afterwards; counters follow from the prior state.
  task automatic tick(input logic [3:0] nxt, input string tag);
    exp_t e;
    if (reset) begin
      m_cyc = '0; m_ins = '0; m_halt = 1'b0; m_err = 1'b0;
    end else begin
      if (cur_st != S_HALT && cur_st != S_ERR) m_cyc = m_cyc + 64'd1;
      if (cur_st == S_COMMIT) m_ins = m_ins + 64'd1;
      if (nxt == S_HALT) m_halt = 1'b1;
      if (nxt == S_ERR) m_err = 1'b1;
    end
    e.tag = tag; e.st = nxt; e.en = dec(nxt);
    e.flags = {m_halt, m_err}; e.cyc = m_cyc; e.ins = m_ins;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (mem_req_o) req_cycles++;
    check_out();
    $display("cycle %s: state=%0d cyc=%0d ins=%0d", tag, state_o, cycle_cnt_o, instr_cnt_o);
    cur_st = nxt;
  endtask

  // Runs one instruction starting in IF. rdy_at: MEM cycle with ready (0 = never).
  task automatic run_instr(input logic ren, input logic wen, input int rdy_at,
                           input logic trap, input string tag);
    mem_ren_i = 1'b0; mem_wen_i = 1'b0; mem_rdy_i = 1'b1; trap_i = 1'b1;
    tick(S_ID, tag);
    tick(S_EX, tag);
    mem_ren_i = ren; mem_wen_i = wen; mem_rdy_i = 1'b0;
    req_cycles = 0;
    if (ren && wen) begin
      tick(S_ERR, tag);
      mem_ren_i = 1'b0; mem_wen_i = 1'b0;
      return;
    end
    if (ren || wen) begin
      tick(S_MEM, tag);
      mem_ren_i = 1'b1; mem_wen_i = 1'b1;
      for (int k = 1; k <= 15; k++) begin
        mem_rdy_i = (k == rdy_at);
        if (mem_rdy_i) begin
          tick(S_WB, tag);
          break;
        end else if (k == 15) begin
          tick(S_ERR, tag);
          mem_ren_i = 1'b0; mem_wen_i = 1'b0;
          return;
        end else begin
          tick(S_MEM, tag);
        end
      end
    end else begin
      tick(S_WB, tag);
    end
    mem_ren_i = 1'b0; mem_wen_i = 1'b0; mem_rdy_i = 1'b1;
    tick(S_COMMIT, tag);
    trap_i = trap;
    tick(trap ? S_HALT : S_IF, tag);
    trap_i = 1'b0; mem_rdy_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ren_i = 1'b0; mem_wen_i = 1'b0; mem_rdy_i = 1'b0; trap_i = 1'b0;
    tick(S_IDLE, "rst");
    tick(S_IDLE, "rst");
    reset = 1'b0;
    tick(S_IF, "dead");
    run_instr(1'b0, 1'b0, 0, 1'b0, "alu1");
    run_instr(1'b0, 1'b0, 0, 1'b0, "alu2");
    run_instr(1'b0, 1'b0, 0, 1'b0, "alu3");
    vectors++;
    assert (cycle_cnt_o === 64'd16) else begin
      miscompares++;
      $error("FAIL alu3_cycles: got %0d expected 16", cycle_cnt_o);
    end
    vectors++;
    assert (instr_cnt_o === 64'd3) else begin
      miscompares++;
      $error("FAIL alu3_instrs: got %0d expected 3", instr_cnt_o);
    end

    reset = 1'b1;
    tick(S_IDLE, "rst2");
    reset = 1'b0;
    tick(S_IF, "dead2");
    run_instr(1'b1, 1'b0, 3, 1'b0, "load");
    vectors++;
    assert (req_cycles === 3) else begin
      miscompares++;
      $error("FAIL load_req_cycles: got %0d expected 3", req_cycles);
    end
    run_instr(1'b0, 1'b1, 15, 1'b0, "tiebrk");
    vectors++;
    assert (err_o === 1'b0) else begin
      miscompares++;
      $error("FAIL tiebrk_err: got %b expected 0", err_o);
    end
    run_instr(1'b0, 1'b0, 0, 1'b0, "alu_c");
    run_instr(1'b0, 1'b0, 0, 1'b1, "trap");
    vectors++;
    assert (instr_cnt_o === 64'd4 && state_o === 4'd7 && halted_o === 1'b1) else begin
      miscompares++;
      $error("FAIL trap_halt: got ins=%0d st=%0d h=%b expected 4/7/1", instr_cnt_o, state_o, halted_o);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rdy_i = i[0]; trap_i = ~i[0]; mem_ren_i = i[1];
      tick(S_HALT, "halt");
    end
    mem_rdy_i = 1'b0; trap_i = 1'b0; mem_ren_i = 1'b0;

    reset = 1'b1;
    tick(S_IDLE, "rst3");
    reset = 1'b0;
    tick(S_IF, "dead3");
    run_instr(1'b0, 1'b1, 0, 1'b0, "timeout");
    for (int i = 0; i < 3; i++) begin
      mem_rdy_i = ~i[0]; trap_i = i[0];
      tick(S_ERR, "err");
    end
    mem_rdy_i = 1'b0; trap_i = 1'b0;

    reset = 1'b1;
    tick(S_IDLE, "rst_err");
    reset = 1'b0;
    tick(S_IF, "dead4");
    tick(S_ID, "abort");
    tick(S_EX, "abort");
    mem_ren_i = 1'b1;
    tick(S_MEM, "abort");
    mem_ren_i = 1'b0;
    tick(S_MEM, "abort");
    reset = 1'b1;
    tick(S_IDLE, "rst_mem");
    reset = 1'b0;
    tick(S_IF, "dead5");
    run_instr(1'b0, 1'b0, 0, 1'b0, "resume");
    run_instr(1'b1, 1'b1, 0, 1'b0, "proto");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_cycle_ctrl.md
Name: inst_cycle_ctrl

Overview:
Multi-cycle instruction sequencer for the single-issue RV64 core. It replaces the free-running 0..7 instruction-cycle counter with an FSM that steps IF -> ID -> EX -> [MEM] -> WB -> COMMIT. The FSM inserts the MEM phase only for loads and stores, and waits on a memory ready handshake with a timeout. It drives per-stage enables, the difftest commit strobe and the cycle/instruction counters, and halts on trap.

Parameters:
MEM_TIMEOUT, 15, max MEM cycles waiting for mem_rdy_i before the error state (range 1..255)
CNT_W, 64, width of cycle_cnt_o and instr_cnt_o

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
mem_ren_i  input  1  decoded instruction is a load; sampled in EX
mem_wen_i  input  1  decoded instruction is a store; sampled in EX
mem_rdy_i  input  1  memory access complete; sampled in MEM only
trap_i  input  1  current instruction is the trap opcode (0x6b); sampled in COMMIT
if_en_o  output  1  fetch enable (state IF)
id_en_o  output  1  decode/regfile read enable (state ID)
ex_en_o  output  1  execute enable (state EX)
mem_req_o  output  1  memory request held (state MEM)
wb_en_o  output  1  regfile write enable gate (state WB)
commit_o  output  1  one-cycle commit strobe (state COMMIT)
state_o  output  4  current state encoding
halted_o  output  1  sticky: trap committed
err_o  output  1  sticky: memory timeout or protocol error
cycle_cnt_o  output  CNT_W  cycles since reset while not halted and not in error
instr_cnt_o  output  CNT_W  committed instructions

Behaviour:
- State encodings: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, COMMIT=6, HALT=7, ERR=8. Only one state register.
- Reset values: state IDLE, all counters 0, halted_o=0, err_o=0. All enables 0 (IDLE decodes to none).
- Stage outputs are pure decodes of the state register. No output is asserted in IDLE, HALT or ERR.
- IDLE -> IF unconditionally. This gives one dead cycle after reset release.
- IF -> ID -> EX, one cycle each, unconditional.
- EX transitions, sampled from mem_ren_i and mem_wen_i:
  - both low -> WB
  - exactly one high -> MEM; wait counter cleared to 0
  - both high -> ERR (protocol error)
- MEM, each cycle:
  - mem_rdy_i=1 -> WB
  - otherwise the wait counter increments; when the counter reaches MEM_TIMEOUT with mem_rdy_i=0 -> ERR
  - rdy in the same cycle the timeout would fire: rdy wins, go to WB
- mem_req_o stays high for the whole MEM dwell. It drops the cycle after rdy is seen.
- WB -> COMMIT unconditional.
- COMMIT:
  - instr_cnt_o increments by 1 at the end of the COMMIT cycle.
  - trap_i=1 -> HALT and set halted_o. The trap instruction itself is counted.
  - trap_i=0 -> IF.
- HALT and ERR are absorbing until reset.
- cycle_cnt_o increments every clock after reset except in HALT and ERR. Both counters wrap modulo 2^CNT_W without flagging.
- Latency:
  - non-memory instruction: 5 cycles, IF to COMMIT inclusive
  - memory instruction with rdy on its first MEM cycle: 6 cycles
  - each extra MEM wait cycle adds 1
- Inputs outside their sampling state are ignored (e.g. mem_rdy_i in IF, trap_i in WB).
- Reset asserted in any state, including mid-MEM: next state IDLE, counters and sticky flags cleared. No commit strobe is produced for the aborted instruction.
- Wait counter width is clog2(MEM_TIMEOUT+1). It never wraps, because the FSM leaves MEM first.

Test Plan:
- Reset for 2 cycles, then 3 ALU instructions (mem_ren/wen=0) -> state sequence 0,1,2,3,5,6,1,... One commit_o pulse every 5 cycles. instr_cnt_o=3 after the third COMMIT; cycle_cnt_o=16 at that point.
- Load with mem_rdy_i high after 3 MEM cycles -> mem_req_o high exactly 3 cycles. Instruction spans 8 cycles, and the WB cycle immediately follows the rdy cycle.
- Store with mem_rdy_i never asserted, MEM_TIMEOUT=15 -> ERR after 15 MEM cycles. err_o=1 and cycle_cnt_o frozen. No commit_o; all enables 0 thereafter.
- Tie-break: mem_rdy_i asserted on exactly the 15th MEM cycle -> WB, err_o stays 0.
- trap_i=1 in COMMIT of the 4th instruction -> halted_o=1, instr_cnt_o=4, state 7. mem_rdy_i/trap_i toggling afterwards has no effect.
- Reset asserted during MEM wait and while in ERR -> next cycle state IDLE, err_o=0, both counters 0. Normal sequencing resumes.
